// File: rtl/test_tone_gen.sv
// Stereo test-tone generator: silence, triangle, sawtooth or square PCM
// at a programmable sample rate derived from the master clock.
module test_tone_gen #(
  parameter int DATA_W = 24,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DIV_W-1:0]  smp_rate_divide,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] l_incrmnt,
  input  logic [DATA_W-1:0] r_incrmnt,
  output logic              l_dout_valid,
  output logic              r_dout_valid,
  output logic [DATA_W-1:0] l_pcm_data,
  output logic [DATA_W-1:0] r_pcm_data
);

  typedef enum logic [1:0] {
    MODE_SILENT = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_SQR    = 2'd3
  } mode_e;

  localparam logic [DATA_W-1:0] MAX_C = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_C = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

  // Triangle arithmetic uses two guard bits so a full-scale step from a
  // clamp point cannot wrap before the compare.
  function automatic logic [DATA_W:0] step(input logic [DATA_W-1:0] acc,
                                           input logic dir,
                                           input logic [DATA_W-1:0] inc,
                                           input mode_e m);
    logic signed [DATA_W+1:0] acc_x, inc_x, sum, dif, mx;
    logic [DATA_W:0] res;
    acc_x = $signed({{2{acc[DATA_W-1]}}, acc});
    inc_x = $signed({2'b00, inc});
    mx    = $signed({2'b00, MAX_C});
    sum   = acc_x + inc_x;
    dif   = acc_x - inc_x;
    res   = '0;
    case (m)
      MODE_SILENT: res = '0;
      MODE_TRI: begin
        if (!dir) begin
          if (sum > mx) res = {1'b1, MAX_C};
          else          res = {1'b0, sum[DATA_W-1:0]};
        end else begin
          if (dif < -mx) res = {1'b0, MIN_C};
          else           res = {1'b1, dif[DATA_W-1:0]};
        end
      end
      default: res = {1'b0, acc + inc};
    endcase
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] acc,
                                              input mode_e m);
    case (m)
      MODE_SILENT: return '0;
      MODE_SQR:    return acc[DATA_W-1] ? MIN_C : MAX_C;
      default:     return acc;
    endcase
  endfunction

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              tick, tick_q, tick_d, mode_chg;
  mode_e             mode_q, mode_d, mode_in;
  logic [DATA_W-1:0] l_acc_q, l_acc_d, r_acc_q, r_acc_d;
  logic              l_dir_q, l_dir_d, r_dir_q, r_dir_d;
  logic [DATA_W-1:0] l_smp_q, l_smp_d, r_smp_q, r_smp_d;
  logic [DATA_W-1:0] l_pcm_q, l_pcm_d, r_pcm_q, r_pcm_d;
  logic              vld_q, vld_d;

  always_comb begin
    mode_in  = mode_e'(mode);
    mode_d   = mode_in;
    mode_chg = (mode_in != mode_q);
    tick     = (cnt_q == smp_rate_divide);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    tick_d   = tick;
    // A mode change clears first; a coincident tick then steps from zero.
    {l_dir_d, l_acc_d} = mode_chg ? '0 : {l_dir_q, l_acc_q};
    {r_dir_d, r_acc_d} = mode_chg ? '0 : {r_dir_q, r_acc_q};
    if (tick) begin
      {l_dir_d, l_acc_d} = step(l_acc_d, l_dir_d, l_incrmnt, mode_in);
      {r_dir_d, r_acc_d} = step(r_acc_d, r_dir_d, r_incrmnt, mode_in);
    end
    l_smp_d = tick ? shape(l_acc_d, mode_in) : l_smp_q;
    r_smp_d = tick ? shape(r_acc_d, mode_in) : r_smp_q;
    vld_d   = tick_q;
    l_pcm_d = tick_q ? l_smp_q : l_pcm_q;
    r_pcm_d = tick_q ? r_smp_q : r_pcm_q;
    if (!run) begin
      cnt_d   = '0;
      tick_d  = 1'b0;
      l_acc_d = '0;
      r_acc_d = '0;
      l_dir_d = 1'b0;
      r_dir_d = 1'b0;
      l_smp_d = '0;
      r_smp_d = '0;
      vld_d   = 1'b0;
      l_pcm_d = '0;
      r_pcm_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      mode_q  <= MODE_SILENT;
      l_acc_q <= '0;
      r_acc_q <= '0;
      l_dir_q <= 1'b0;
      r_dir_q <= 1'b0;
      l_smp_q <= '0;
      r_smp_q <= '0;
      vld_q   <= 1'b0;
      l_pcm_q <= '0;
      r_pcm_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      l_acc_q <= l_acc_d;
      r_acc_q <= r_acc_d;
      l_dir_q <= l_dir_d;
      r_dir_q <= r_dir_d;
      l_smp_q <= l_smp_d;
      r_smp_q <= r_smp_d;
      vld_q   <= vld_d;
      l_pcm_q <= l_pcm_d;
      r_pcm_q <= r_pcm_d;
    end
  end

  assign l_dout_valid = vld_q;
  assign r_dout_valid = vld_q;
  assign l_pcm_data   = l_pcm_q;
  assign r_pcm_data   = r_pcm_q;

endmodule
